// File: rtl/des_pkg.sv
// Shared definitions for the DES core arbiter.
//   DW           : data/key width of the shared DES core
//   CORE_LATENCY : cycles from the core sampling load to valid data_out
//   req_id_t     : requester identifier (0 or 1)
//   tag_t        : in-flight job tag {v, id}
package des_pkg;

  localparam int unsigned DW           = 64;
  localparam int unsigned CORE_LATENCY = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/des_tag_pipe.sv
// Shift register of job tags that tracks jobs inside the DES core.
// Ports:
//   i_clk     : clock
//   i_clr     : synchronous clear, invalidates every stage
//   i_v, i_id : tag entering stage 1 this cycle
//   o_last_v  : last stage holds a valid job (core output valid now)
//   o_last_id : requester that owns the job in the last stage
//   o_any_v   : any stage holds a valid job
module des_tag_pipe
  import des_pkg::*;
#(
  parameter int unsigned Depth = CORE_LATENCY
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_v,
  input  logic i_id,
  output logic o_last_v,
  output logic o_last_id,
  output logic o_any_v
);

  tag_t r_stage [Depth];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= '{v: i_v, id: i_id};
      for (int unsigned k = 1; k < Depth; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_comb begin
    o_any_v = 1'b0;
    for (int unsigned k = 0; k < Depth; k++) begin
      o_any_v = o_any_v | r_stage[k].v;
    end
  end

  assign o_last_v  = r_stage[Depth-1].v;
  assign o_last_id = r_stage[Depth-1].id;

endmodule

// File: rtl/des_core_arbiter.sv
// Round-robin sharing of one pipelined DES core between two requesters.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pause                 : blocks new grants; in-flight jobs still drain
//   reqN_valid/key/data   : requester N job (held stable until ready)
//   reqN_ready            : job accepted this cycle (combinational grant)
//   core_load/key/data    : drive the shared core inputs
//   core_dout             : core output, valid when the last tag stage is valid
//   rspN_valid/data       : registered one-cycle ciphertext pulse to requester N
//   busy                  : a job is in flight or a response is being presented
module des_core_arbiter
  import des_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = des_pkg::CORE_LATENCY,
  parameter int unsigned DW           = des_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pause,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_key,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_key,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          core_load,
  output logic [DW-1:0] core_key,
  output logic [DW-1:0] core_data,
  input  logic [DW-1:0] core_dout,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          busy
);

  logic          r_prio;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_last_v;
  req_id_t       w_last_id;
  logic          w_any_v;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic [DW-1:0] r_rsp0_data;
  logic [DW-1:0] r_rsp1_data;

  // Grant: a lone requester wins outright; on contention r_prio decides.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset && !pause) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign core_load  = w_grant0 | w_grant1;

  always_comb begin
    core_key  = '0;
    core_data = '0;
    if (w_grant0) begin
      core_key  = req0_key;
      core_data = req0_data;
    end else if (w_grant1) begin
      core_key  = req1_key;
      core_data = req1_data;
    end
  end

  // The requester just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_grant0) begin
      r_prio <= 1'b1;
    end else if (w_grant1) begin
      r_prio <= 1'b0;
    end
  end

  des_tag_pipe #(
    .Depth (CORE_LATENCY)
  ) u_tag_pipe (
    .i_clk     (clk),
    .i_clr     (reset),
    .i_v       (core_load),
    .i_id      (w_grant1),
    .o_last_v  (w_last_v),
    .o_last_id (w_last_id),
    .o_any_v   (w_any_v)
  );

  // Capture the core output in the cycle its tag reaches the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_rsp0_valid <= w_last_v && !w_last_id;
      r_rsp1_valid <= w_last_v && w_last_id;
      if (w_last_v && !w_last_id) begin
        r_rsp0_data <= core_dout;
      end
      if (w_last_v && w_last_id) begin
        r_rsp1_data <= core_dout;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign busy       = w_any_v | r_rsp0_valid | r_rsp1_valid;

endmodule

// File: tb/tb_des_core_arbiter.sv
// Bench for des_core_arbiter: two DUT instances (core latency 2 and 4) share one
// stimulus stream; each has its own DES core model and job-queue reference model.
module tb_des_core_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [63:0] req0_key = '0;
  logic [63:0] req0_data = '0;
  logic [63:0] req1_key = '0;
  logic [63:0] req1_data = '0;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) n <= n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- DES model
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                   28,29,30,31,32,1};
  int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                     16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
  int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Tables use DES numbering: bit 1 is the MSB.
  function automatic logic [63:0] des_enc(input logic [63:0] key, input logic [63:0] pt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [63:0] ipv, pre, ct;
    logic [31:0] l, r, f, sout, tmp;
    logic [47:0] e;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rn = 0; rn < 16; rn++) begin
      for (int s = 0; s < sh_t[rn]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[rn][47-i] = cd[56-pc2_t[i]];
    end
    for (int i = 0; i < 64; i++) ipv[63-i] = pt[64-ip_t[i]];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rn = 0; rn < 16; rn++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
      e = e ^ sk[rn];
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        row = {30'b0, six[5], six[0]};
        col = {28'b0, six[4:1]};
        sout[31-4*s -: 4] = 4'(sbox_t[s*64 + row*16 + col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-p_t[i]];
      tmp = l ^ f;
      l   = r;
      r   = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) ct[63-i] = pre[64-fp_t[i]];
    return ct;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  typedef struct {
    logic        id;
    logic [63:0] ct;
    int          due;
  } job_t;

  // ------------------------------------------------- DUTs, cores and models
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int    LAT = (g == 0) ? 2 : 4;
    localparam string TAG = (g == 0) ? "lat2" : "lat4";

    logic        ready0, ready1, core_load, rsp0_valid, rsp1_valid, busy;
    logic [63:0] core_key, core_data, core_dout, rsp0_data, rsp1_data;
    logic [63:0] pipe [LAT];
    int          n_rsp0 = 0;
    int          n_rsp1 = 0;

    des_core_arbiter #(
      .CORE_LATENCY (LAT),
      .DW           (64)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .pause      (pause),
      .req0_valid (req0_valid),
      .req0_key   (req0_key),
      .req0_data  (req0_data),
      .req0_ready (ready0),
      .req1_valid (req1_valid),
      .req1_key   (req1_key),
      .req1_data  (req1_data),
      .req1_ready (ready1),
      .core_load  (core_load),
      .core_key   (core_key),
      .core_data  (core_data),
      .core_dout  (core_dout),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .busy       (busy)
    );

    // Pipelined core: inputs sampled at posedge, result LAT cycles later.
    always @(posedge clk) begin
      pipe[0] <= core_load ? des_enc(core_key, core_data) : 64'h0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign core_dout = pipe[LAT-1];

    // Reference model: queue of accepted jobs, each with its due cycle.
    job_t        q[$];
    logic        m_prio;
    logic [63:0] m_last0, m_last1;
    logic        exp_r0, exp_r1, exp_busy, eg0, eg1;

    always @(negedge clk) begin
      if (rsp0_valid) n_rsp0++;
      if (rsp1_valid) n_rsp1++;
      if (reset) begin
        chk({TAG, " ready0 in reset"}, 64'(ready0), 64'(0));
        chk({TAG, " ready1 in reset"}, 64'(ready1), 64'(0));
        chk({TAG, " core_load in reset"}, 64'(core_load), 64'(0));
        q.delete();
        m_prio  = 1'b0;
        m_last0 = '0;
        m_last1 = '0;
      end else begin
        exp_r0   = 1'b0;
        exp_r1   = 1'b0;
        exp_busy = (q.size() != 0);
        if (q.size() != 0 && q[0].due == n) begin
          if (q[0].id) begin
            exp_r1  = 1'b1;
            m_last1 = q[0].ct;
          end else begin
            exp_r0  = 1'b1;
            m_last0 = q[0].ct;
          end
          void'(q.pop_front());
        end
        chk({TAG, " rsp0_valid"}, 64'(rsp0_valid), 64'(exp_r0));
        chk({TAG, " rsp1_valid"}, 64'(rsp1_valid), 64'(exp_r1));
        chk({TAG, " rsp0_data"}, rsp0_data, m_last0);
        chk({TAG, " rsp1_data"}, rsp1_data, m_last1);
        chk({TAG, " busy"}, 64'(busy), 64'(exp_busy));

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!pause) begin
          if (req0_valid && req1_valid) begin
            eg0 = !m_prio;
            eg1 = m_prio;
          end else begin
            eg0 = req0_valid;
            eg1 = req1_valid;
          end
        end
        chk({TAG, " ready0"}, 64'(ready0), 64'(eg0));
        chk({TAG, " ready1"}, 64'(ready1), 64'(eg1));
        chk({TAG, " core_load"}, 64'(core_load), 64'(eg0 | eg1));
        chk({TAG, " core_key"}, core_key, eg0 ? req0_key : (eg1 ? req1_key : 64'h0));
        chk({TAG, " core_data"}, core_data, eg0 ? req0_data : (eg1 ? req1_data : 64'h0));
        if (eg0 || eg1) begin
          q.push_back('{id: eg1,
                        ct: eg1 ? des_enc(req1_key, req1_data) : des_enc(req0_key, req0_data),
                        due: n + 1 + LAT});
          m_prio = eg0;
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic do_reset(input int cyc);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (cyc) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((gi[0].busy || gi[1].busy) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " drain busy"}, 64'(gi[0].busy | gi[1].busy), 64'(0));
  endtask

  logic a0, a1;
  int   lat_a, lat_b, busy_a, busy_b, r1_seen, g_cnt, c0, c1, guard;
  int   s00, s01, s10, s11;

  task automatic snap();
    s00 = gi[0].n_rsp0;
    s01 = gi[0].n_rsp1;
    s10 = gi[1].n_rsp0;
    s11 = gi[1].n_rsp1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", 64'(i == 0 ? gi[0].busy : gi[1].busy), 64'(0));
    end
    chk("reset rsp valid", 64'({gi[0].rsp0_valid, gi[0].rsp1_valid}), 64'(0));
    chk("reset rsp0_data", gi[0].rsp0_data, 64'h0);
    chk("reset rsp1_data", gi[1].rsp1_data, 64'h0);

    // Single job with the classic DES vector
    @(posedge clk);
    #1 req0_valid = 1'b1;
    req0_key  = 64'h133457799BBCDFF1;
    req0_data = 64'h0123456789ABCDEF;
    @(negedge clk);
    chk("t1 ready", 64'({gi[0].ready0, gi[0].ready1}), 64'(2'b10));
    @(posedge clk);
    #1 req0_valid = 1'b0;
    lat_a = -1; lat_b = -1; busy_a = 0; busy_b = 0; r1_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (gi[0].rsp0_valid && lat_a < 0) begin
        lat_a = k;
        chk("t1 lat2 data", gi[0].rsp0_data, 64'h85E813540F0AB405);
      end
      if (gi[1].rsp0_valid && lat_b < 0) begin
        lat_b = k;
        chk("t1 lat4 data", gi[1].rsp0_data, 64'h85E813540F0AB405);
      end
      busy_a += int'(gi[0].busy);
      busy_b += int'(gi[1].busy);
      r1_seen += int'(gi[0].rsp1_valid) + int'(gi[1].rsp1_valid);
    end
    chk("t1 lat2 latency", 64'(lat_a), 64'(3));
    chk("t1 lat4 latency", 64'(lat_b), 64'(5));
    chk("t1 lat2 busy cycles", 64'(busy_a), 64'(3));
    chk("t1 lat4 busy cycles", 64'(busy_b), 64'(5));
    chk("t1 rsp1 never", 64'(r1_seen), 64'(0));

    // Contention: both valid, 6 jobs each, alternating from prio 0
    do_reset(2);
    snap();
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_key = rnd64(); req0_data = rnd64();
    req1_valid = 1'b1; req1_key = rnd64(); req1_data = rnd64();
    g_cnt = 0; c0 = 0; c1 = 0; guard = 0;
    while ((req0_valid || req1_valid) && guard < 30) begin
      @(negedge clk);
      a0 = gi[0].ready0;
      a1 = gi[0].ready1;
      chk("t2 grant order", 64'({a0, a1}), (g_cnt % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      g_cnt++;
      @(posedge clk);
      #1;
      if (a0) begin
        c0++;
        if (c0 == 6) req0_valid = 1'b0;
        else begin req0_key = rnd64(); req0_data = rnd64(); end
      end
      if (a1) begin
        c1++;
        if (c1 == 6) req1_valid = 1'b0;
        else begin req1_key = rnd64(); req1_data = rnd64(); end
      end
      guard++;
    end
    chk("t2 grant count", 64'(g_cnt), 64'(12));
    drain("t2");
    chk("t2 lat2 rsp0 count", 64'(gi[0].n_rsp0 - s00), 64'(6));
    chk("t2 lat2 rsp1 count", 64'(gi[0].n_rsp1 - s01), 64'(6));
    chk("t2 lat4 rsp0 count", 64'(gi[1].n_rsp0 - s10), 64'(6));
    chk("t2 lat4 rsp1 count", 64'(gi[1].n_rsp1 - s11), 64'(6));

    // Back-to-back single requester
    snap();
    @(posedge clk);
    #1 req1_valid = 1'b1; req1_key = rnd64(); req1_data = rnd64();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3 ready1 every cycle", 64'({gi[0].ready0, gi[0].ready1}), 64'(2'b01));
      @(posedge clk);
      #1 req1_key = rnd64(); req1_data = rnd64();
    end
    req1_valid = 1'b0;
    drain("t3");
    chk("t3 lat2 rsp1 count", 64'(gi[0].n_rsp1 - s01), 64'(8));
    chk("t3 lat4 rsp1 count", 64'(gi[1].n_rsp1 - s11), 64'(8));
    @(posedge clk);
    #1 req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t3 prio 0 after", 64'({gi[0].ready0, gi[0].ready1}), 64'(2'b10));
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t3b");

    // Pause after two grants (prio is 1 here)
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_key = rnd64(); req0_data = rnd64();
    req1_valid = 1'b1; req1_key = rnd64(); req1_data = rnd64();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a0 = gi[0].ready0;
      a1 = gi[0].ready1;
      @(posedge clk);
      #1;
      if (a0) begin req0_key = rnd64(); req0_data = rnd64(); end
      if (a1) begin req1_key = rnd64(); req1_data = rnd64(); end
    end
    snap();
    pause = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4 no ready while paused", 64'({gi[0].ready0, gi[0].ready1}), 64'(0));
    end
    chk("t4 lat2 drained rsp", 64'(gi[0].n_rsp0 + gi[0].n_rsp1 - s00 - s01), 64'(2));
    chk("t4 lat4 drained rsp", 64'(gi[1].n_rsp0 + gi[1].n_rsp1 - s10 - s11), 64'(2));
    chk("t4 busy low in pause", 64'(gi[0].busy | gi[1].busy), 64'(0));
    @(posedge clk);
    #1 pause = 1'b0;
    @(negedge clk);
    chk("t4 grant after release", 64'({gi[0].ready0, gi[0].ready1}), 64'(2'b01));
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t4");

    // Reset with two jobs in flight
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_key = rnd64(); req0_data = rnd64();
    req1_valid = 1'b1; req1_key = rnd64(); req1_data = rnd64();
    @(negedge clk);
    a0 = gi[0].ready0;
    @(posedge clk);
    #1;
    if (a0) begin req0_key = rnd64(); req0_data = rnd64(); end
    else begin req1_key = rnd64(); req1_data = rnd64(); end
    @(negedge clk);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5 lat2 quiet", 64'({gi[0].rsp0_valid, gi[0].rsp1_valid, gi[0].busy}), 64'(0));
      chk("t5 lat4 quiet", 64'({gi[1].rsp0_valid, gi[1].rsp1_valid, gi[1].busy}), 64'(0));
    end
    snap();
    @(posedge clk);
    #1 req0_valid = 1'b1; req1_valid = 1'b1;
    req0_key = rnd64(); req0_data = rnd64();
    @(negedge clk);
    chk("t5 prio 0 after reset", 64'({gi[0].ready0, gi[0].ready1}), 64'(2'b10));
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t5");
    chk("t5 lat2 new job", 64'(gi[0].n_rsp0 - s00), 64'(1));
    chk("t5 lat4 new job", 64'(gi[1].n_rsp0 - s10), 64'(1));

    // Randomized traffic with pause and occasional reset
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = req0_valid && gi[0].ready0;
      a1 = req1_valid && gi[0].ready1;
      @(posedge clk);
      #1;
      pause = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_key   = rnd64();
        req0_data  = rnd64();
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_key   = rnd64();
        req1_data  = rnd64();
      end
    end
    reset = 1'b0; pause = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t6");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
